// File: rtl/sb_register_bank.sv
// sb_register_bank
// Receiving end of the CPU special bus (SB). Holds the X, Y, accumulator and
// stack pointer registers, loads them from SB under per-register strobes, and
// produces N/Z flag candidates for every X/Y/AC load.
//
// The stack pointer is two latches: an input latch loaded from SB and an
// output latch that copies the input latch on every edge. The visible stack
// pointer therefore lags an SB_S strobe by two edges.
//
// Optional feature macro: STACK_INC_DEC_EN
//   defined   -> S_Inc/S_Dec ports exist and step the input latch
//                (modulo 2^WIDTH). SB_S has priority over stepping, and
//                S_Inc together with S_Dec leaves the latch unchanged.
//   undefined -> ports absent; the stack pointer changes only through SB_S.
//
// Reset is synchronous, active-low, and wins over every strobe on that edge.

module sb_register_bank #(
  parameter int unsigned     WIDTH   = 8,
  parameter logic [WIDTH-1:0] S_RESET = 8'hFD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] SB,
  input  logic             SB_X,
  input  logic             SB_Y,
  input  logic             SB_AC,
  input  logic             SB_S,
`ifdef STACK_INC_DEC_EN
  input  logic             S_Inc,
  input  logic             S_Dec,
`endif
  output logic [WIDTH-1:0] X_Index_Register_Out,
  output logic [WIDTH-1:0] Y_Index_Register_Out,
  output logic [WIDTH-1:0] Accumulator_Out,
  output logic [WIDTH-1:0] Stack_Pointer_Register_Out,
  output logic             NZ_Valid,
  output logic             N_Flag,
  output logic             Z_Flag
);

  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic [WIDTH-1:0] s_in_q, s_in_d;
  logic [WIDTH-1:0] s_out_q, s_out_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic             nzv_q, nzv_d;

  logic             flag_load;
  logic             s_step_up;
  logic             s_step_dn;

  assign flag_load = SB_X | SB_Y | SB_AC;

`ifdef STACK_INC_DEC_EN
  // Stepping only when exactly one of inc/dec is asserted.
  assign s_step_up = S_Inc & ~S_Dec;
  assign s_step_dn = S_Dec & ~S_Inc;
`else
  assign s_step_up = 1'b0;
  assign s_step_dn = 1'b0;
`endif

  // Index registers and accumulator: load from SB on strobe, otherwise hold.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    ac_d = ac_q;
    if (SB_X)  x_d  = SB;
    if (SB_Y)  y_d  = SB;
    if (SB_AC) ac_d = SB;
  end

  // Stack pointer input latch: SB load beats stepping; output latch always
  // copies the input latch so it trails it by exactly one edge.
  always_comb begin
    s_in_d = s_in_q;
    if (SB_S) begin
      s_in_d = SB;
    end else if (s_step_up) begin
      s_in_d = s_in_q + WIDTH'(1);
    end else if (s_step_dn) begin
      s_in_d = s_in_q - WIDTH'(1);
    end
    s_out_d = s_in_q;
  end

  // Flag candidates: refreshed by any X/Y/AC load, held otherwise.
  always_comb begin
    n_d   = n_q;
    z_d   = z_q;
    nzv_d = 1'b0;
    if (flag_load) begin
      n_d   = SB[WIDTH-1];
      z_d   = (SB == '0);
      nzv_d = 1'b1;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      ac_q    <= '0;
      s_in_q  <= S_RESET;
      s_out_q <= S_RESET;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      nzv_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      ac_q    <= ac_d;
      s_in_q  <= s_in_d;
      s_out_q <= s_out_d;
      n_q     <= n_d;
      z_q     <= z_d;
      nzv_q   <= nzv_d;
    end
  end

  assign X_Index_Register_Out       = x_q;
  assign Y_Index_Register_Out       = y_q;
  assign Accumulator_Out            = ac_q;
  assign Stack_Pointer_Register_Out = s_out_q;
  assign NZ_Valid                   = nzv_q;
  assign N_Flag                     = n_q;
  assign Z_Flag                     = z_q;

endmodule
